mem_port_arbiter: RTL

Arbitrates the core's instruction-fetch port and data-access port onto one shared, single-outstanding external memory port. Sits between the core (fetch and mem_access sides) and the unified memory or cache interface. Serialises transactions and returns read data to the requester with a one-cycle active-low ready pulse. Data accesses have priority, and a starvation guard ensures fetch still makes progress.

---
 rtl/mem_port_arbiter.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-outstanding external memory port
// between the instruction-fetch and data-access sides of the core. Data
// accesses win arbitration. A saturating counter forces a fetch grant once
// STARVE_MAX consecutive data grants have been made while fetch was waiting.
// Each completed transaction returns a one-cycle active-low ready pulse to
// the requester that was served.
module mem_port_arbiter #(
    parameter int STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        rst,
    // fetch side
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic [31:0] i_rdata,
    output logic        iready_n,
    // data side
    input  logic        d_req,
    input  logic        d_write,
    input  logic [1:0]  d_size,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        dready_n,
    output logic        dbusy,
    // external memory port
    output logic        m_req,
    output logic        m_write,
    output logic [1:0]  m_size,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    input  logic [31:0] m_rdata,
    input  logic        mready_n
);

    localparam int          SW       = $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] STARVE_TOP = SW'(STARVE_MAX);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        I_BUSY = 2'd1,
        D_BUSY = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t        r_state;
    logic [SW-1:0] r_starve;

    logic          r_m_req;
    logic          r_m_write;
    logic [1:0]    r_m_size;
    logic [31:0]   r_m_addr;
    logic [31:0]   r_m_wdata;
    logic [31:0]   r_i_rdata;
    logic [31:0]   r_d_rdata;
    logic          r_iready_n;
    logic          r_dready_n;
    logic          r_dbusy;

    logic          w_arb;
    logic          w_starved;
    logic          w_grant_d;
    logic          w_grant_i;

    // Arbitration happens only on edges that leave IDLE or RESP.
    assign w_arb     = (r_state == IDLE) || (r_state == RESP);
    // Fetch is waiting and the data side has used up its consecutive grants.
    assign w_starved = i_req && (r_starve == STARVE_TOP);
    assign w_grant_d = w_arb && d_req && !w_starved;
    assign w_grant_i = w_arb && !w_grant_d && i_req;

    // Transaction FSM with all outputs registered.
    // NOTE: every register here is state, so all assignments are non-blocking;
    // blocking ones would make the result depend on statement order and on
    // how other processes are scheduled at the same edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= IDLE;
            r_starve   <= '0;
            r_m_req    <= 1'b0;
            r_m_write  <= 1'b0;
            r_m_size   <= 2'b00;
            r_m_addr   <= '0;
            r_m_wdata  <= '0;
            r_i_rdata  <= '0;
            r_d_rdata  <= '0;
            r_iready_n <= 1'b1;
            r_dready_n <= 1'b1;
            r_dbusy    <= 1'b0;
        end else begin
            // The counter only measures data grants while fetch is asking.
            if (!i_req || w_grant_i) begin
                r_starve <= '0;
            end else if (w_grant_d && (r_starve != STARVE_TOP)) begin
                r_starve <= r_starve + 1'b1;
            end

            case (r_state)
                IDLE, RESP: begin
                    r_iready_n <= 1'b1;
                    r_dready_n <= 1'b1;
                    if (w_grant_d) begin
                        r_state   <= D_BUSY;
                        r_m_req   <= 1'b1;
                        r_m_write <= d_write;
                        r_m_size  <= d_size;
                        r_m_addr  <= d_addr;
                        r_m_wdata <= d_wdata;
                    end else if (w_grant_i) begin
                        // Fetches are always word loads; write data is left alone.
                        r_state   <= I_BUSY;
                        r_m_req   <= 1'b1;
                        r_m_write <= 1'b0;
                        r_m_size  <= 2'b10;
                        r_m_addr  <= i_addr;
                        r_dbusy   <= 1'b1;
                    end else begin
                        r_state   <= IDLE;
                    end
                end

                I_BUSY: begin
                    if (!mready_n) begin
                        r_state    <= RESP;
                        r_m_req    <= 1'b0;
                        r_i_rdata  <= m_rdata;
                        r_iready_n <= 1'b0;
                        r_dbusy    <= 1'b0;
                    end
                end

                D_BUSY: begin
                    if (!mready_n) begin
                        r_state    <= RESP;
                        r_m_req    <= 1'b0;
                        // The registered direction is used: d_write may already
                        // have moved on to the requester's next access.
                        if (!r_m_write) begin
                            r_d_rdata <= m_rdata;
                        end
                        r_dready_n <= 1'b0;
                    end
                end

                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign m_req    = r_m_req;
    assign m_write  = r_m_write;
    assign m_size   = r_m_size;
    assign m_addr   = r_m_addr;
    assign m_wdata  = r_m_wdata;
    assign i_rdata  = r_i_rdata;
    assign d_rdata  = r_d_rdata;
    assign iready_n = r_iready_n;
    assign dready_n = r_dready_n;
    assign dbusy    = r_dbusy;

endmodule
